// File: rtl/jump_autopilot.sv
// Autopilot for the dinosaur game: counts obstacle pixels in a lookahead window
// and pulses block_controller's up input. Define AUTOSTART_EN to also start the game from INI.
module jump_autopilot #(
    parameter int          LOOK_X0         = 240,
    parameter int          LOOK_X1         = 300,
    parameter int          LOOK_Y0         = 480,
    parameter int          LOOK_Y1         = 515,
    parameter logic [11:0] BG_COLOR        = 12'hFFF,
    parameter int          HIT_THRESH      = 4,
    parameter int          PULSE_CYC       = 2,
    parameter int          COOLDOWN_FRAMES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [11:0] rgb,
    input  logic [3:0]  state,
    output logic [1:0]  up,
    output logic [15:0] jump_count,
    output logic        busy,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_FIRE  = 3'd2,
        S_COOL  = 3'd3,
        S_START = 3'd4
    } fsm_t;

    fsm_t        state_q, state_d;
    logic [19:0] hv_q;
    logic [7:0]  pix_q, pix_d;
    logic [7:0]  pulse_q, pulse_d;
    logic [7:0]  cd_q, cd_d;
    logic [1:0]  up_q, up_d;
    logic [15:0] jc_q, jc_d;
    logic        busy_q, busy_d;

    logic strobe, frame_start, in_win, hit, play, pulse_done;

    // A pixel is seen once, however many clk cycles the VGA timing holds it.
    assign strobe      = ({hCount, vCount} != hv_q);
    assign frame_start = strobe && (hCount == 10'd0) && (vCount == 10'd0);
    assign in_win      = (int'(hCount) >= LOOK_X0) && (int'(hCount) < LOOK_X1) &&
                         (int'(vCount) >= LOOK_Y0) && (int'(vCount) < LOOK_Y1);
    assign hit         = strobe && bright && in_win && (rgb != BG_COLOR);
    assign play        = enable && (state == 4'd2);
    assign pulse_done  = (pulse_q == 8'(PULSE_CYC - 1));

`ifdef AUTOSTART_EN
    logic [1:0] ini_cnt_q, ini_cnt_d;
    logic       started_q, started_d;
    logic       ini_cond, start_go;

    assign ini_cond = enable && (state == 4'd1);
    assign start_go = ini_cond && !started_q && frame_start && (ini_cnt_q == 2'd1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hv_q    <= '0;
            pix_q   <= '0;
            pulse_q <= '0;
            cd_q    <= '0;
            up_q    <= '0;
            jc_q    <= '0;
            busy_q  <= 1'b0;
`ifdef AUTOSTART_EN
            ini_cnt_q <= '0;
            started_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hv_q    <= {hCount, vCount};
            pix_q   <= pix_d;
            pulse_q <= pulse_d;
            cd_q    <= cd_d;
            up_q    <= up_d;
            jc_q    <= jc_d;
            busy_q  <= busy_d;
`ifdef AUTOSTART_EN
            ini_cnt_q <= ini_cnt_d;
            started_q <= started_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (play) state_d = S_SCAN;
`ifdef AUTOSTART_EN
                else if (start_go) state_d = S_START;
`endif
            end
            S_SCAN: if (frame_start && (pix_q >= 8'(HIT_THRESH))) state_d = S_FIRE;
            S_FIRE: if (pulse_done) state_d = S_COOL;
            S_COOL: if (frame_start && (cd_q == 8'(COOLDOWN_FRAMES - 1))) state_d = S_SCAN;
`ifdef AUTOSTART_EN
            S_START: if (pulse_done || !ini_cond) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        // Leaving PLAY or disabling aborts whatever the game-play states were doing.
        if (!play && (state_q inside {S_SCAN, S_FIRE, S_COOL})) state_d = S_IDLE;
    end

    always_comb begin
        up_d   = {1'b0, (state_d == S_FIRE) || (state_d == S_START)};
        busy_d = (state_d == S_FIRE) || (state_d == S_COOL);
        jc_d   = jc_q;
        if ((state_d == S_FIRE) && (state_q != S_FIRE) && (jc_q != 16'hFFFF)) jc_d = jc_q + 16'd1;

        pulse_d = '0;
        if (((state_q == S_FIRE) || (state_q == S_START)) && (state_d == state_q)) pulse_d = pulse_q + 8'd1;

        cd_d = '0;
        if ((state_q == S_COOL) && (state_d == S_COOL)) cd_d = cd_q + {7'd0, frame_start};

        pix_d = pix_q;
        if (frame_start || ((state_d == S_SCAN) && (state_q != S_SCAN))) pix_d = '0;
        else if ((state_q == S_SCAN) && hit && (pix_q != 8'hFF)) pix_d = pix_q + 8'd1;

`ifdef AUTOSTART_EN
        ini_cnt_d = ini_cnt_q;
        if (!ini_cond || started_q || (state_q != S_IDLE)) ini_cnt_d = '0;
        else if (frame_start && (ini_cnt_q != 2'd3)) ini_cnt_d = ini_cnt_q + 2'd1;
        started_d = started_q;
        if (state != 4'd1) started_d = 1'b0;
        else if (state_q == S_START) started_d = 1'b1;
`endif
    end

    assign up         = up_q;
    assign jump_count = jc_q;
    assign busy       = busy_q;
    assign fsm_state  = state_q;

endmodule
